trg_sci_pkt_gen: RTL and testbench

//  Next-generation trigger science-data packetiser. On each enabled coincidence trigger it snapshots
//  the trigger state and streams one framed, CRC-protected byte packet into an internal FIFO.
//  The FIFO is read by the readout controller. Generalised over N_MODE trigger modes and hit width.

---
 rtl/trg_sci_pkt_gen.sv | 175 +++++++++++++++++
 tb/tb_trg_sci_pkt_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trg_sci_pkt_gen.sv
// Trigger science-data packetiser: snapshots trigger state on an enabled trigger
// and streams one framed, CRC-16 protected byte packet into a single-clock FIFO.
module trg_sci_pkt_gen #(
  parameter int          N_MODE     = 6,
  parameter int          HIT_W      = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter int          AW         = 6,
  parameter logic [15:0] SYNC_WORD  = 16'hEB90
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                trg_enb_sig,
  input  logic                coincid_trg_in,
  input  logic [8*N_MODE-1:0] trg_mode_in,
  input  logic [HIT_W-1:0]    hit_sig_stus_in,
  input  logic [15:0]         eff_trg_cnt_in,
  input  logic [23:0]         trg_busy_time_cnt_in,
  input  logic                trg_busy_timer_rdy_in,
  input  logic                fifo_rd_in,
  output logic [7:0]          fifo_data_out,
  output logic                fifo_empty_out,
  output logic [AW:0]         fifo_count_out,
  output logic [15:0]         frame_drop_cnt_out,
  output logic                busy_out
);

  localparam int FRAME_BYTES = 13 + HIT_W / 8;
  localparam int SH_W        = (FRAME_BYTES - 2) * 8;
  localparam int CW          = $clog2(FRAME_BYTES);
  localparam logic [AW:0] MAX_CNT = (AW + 1)'(FIFO_DEPTH - FRAME_BYTES);
  localparam logic [CW-1:0] LAST_IX = CW'(FRAME_BYTES - 3);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CRC_HI,
    CRC_LO
  } state_t;

  state_t          state_q, state_d;
  logic [SH_W-1:0] sh_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     crc_q;
  logic [15:0]     seq_q;
  logic [15:0]     drop_q;
  logic [7:0]      sel_q, sel_d;
  logic [7:0]      mode_q, mode_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q;

  logic            trig, fits, accept, drop, seq_inc;
  logic            wr_en, rd_en;
  logic [7:0]      wr_data;

  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0]  d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Lowest enabled index wins, so scan from the top down.
  always_comb begin
    sel_d  = 8'h00;
    mode_d = 8'h00;
    for (int i = N_MODE - 1; i >= 0; i--) begin
      if (trg_mode_in[8*i+6 +: 2] == 2'b01) begin
        sel_d  = {1'b1, 7'(i)};
        mode_d = trg_mode_in[8*i +: 8];
      end
    end
  end

  assign trig  = coincid_trg_in & trg_enb_sig;
  assign fits  = count_q <= MAX_CNT;
  assign rd_en = fifo_rd_in & (count_q != '0);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    seq_inc = 1'b0;
    wr_en   = 1'b0;
    wr_data = sh_q[SH_W-1 -: 8];
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          seq_inc = 1'b1;
          if (fits) begin
            accept  = 1'b1;
            state_d = SEND;
          end else begin
            drop = 1'b1;
          end
        end
      end
      SEND: begin
        wr_en = 1'b1;
        if (cnt_q == LAST_IX) state_d = CRC_HI;
      end
      CRC_HI: begin
        wr_en   = 1'b1;
        wr_data = crc_q[15:8];
        state_d = CRC_LO;
      end
      CRC_LO: begin
        wr_en   = 1'b1;
        wr_data = crc_q[7:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (trig && state_q != IDLE) drop = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      crc_q   <= 16'hFFFF;
      seq_q   <= '0;
      drop_q  <= '0;
      sel_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      if (seq_inc) seq_q <= seq_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (accept) begin
        sh_q  <= {SYNC_WORD, seq_q, sel_q, mode_q, hit_sig_stus_in,
                  eff_trg_cnt_in,
                  trg_busy_timer_rdy_in ? trg_busy_time_cnt_in : 24'hFFFFFF};
        cnt_q <= '0;
        crc_q <= 16'hFFFF;
      end else if (state_q == SEND) begin
        sh_q  <= {sh_q[SH_W-9:0], 8'h00};
        cnt_q <= cnt_q + 1'b1;
        // The sync word is the first two bytes and stays out of the CRC.
        if (cnt_q >= CW'(2)) crc_q <= crc_byte(crc_q, wr_data);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      if (wr_en && !rd_en) count_q <= count_q + 1'b1;
      else if (!wr_en && rd_en) count_q <= count_q - 1'b1;
    end
  end

  assign fifo_empty_out     = (count_q == '0);
  assign fifo_data_out      = fifo_empty_out ? 8'h00 : mem_q[rptr_q];
  assign fifo_count_out     = count_q;
  assign frame_drop_cnt_out = drop_q;
  assign busy_out           = (state_q != IDLE);

endmodule

// File: tb/tb_trg_sci_pkt_gen.sv
// Bench for trg_sci_pkt_gen: byte-queue model of frames and FIFO checked
// every cycle, plus literal expectations on drained frames.
module tb_trg_sci_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enb = 1'b1;
  logic        trg = 1'b0;
  logic [47:0] modes = '0;
  logic [15:0] hit = '0;
  logic [15:0] eff = '0;
  logic [23:0] btime = '0;
  logic        rdy = 1'b1;
  logic        rd = 1'b0;
  logic [7:0]  dout;
  logic        empty;
  logic [6:0]  cnt;
  logic [15:0] drops;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  logic [7:0]  mq[$];
  logic [7:0]  mp[$];
  logic [15:0] m_seq, m_drop;
  logic [7:0]  m_sel, m_mode;
  int          pre;
  bit          idle;
  logic [7:0]  got[64];

  trg_sci_pkt_gen dut (
    .clk_in(clk),
    .rst_in(rst),
    .trg_enb_sig(enb),
    .coincid_trg_in(trg),
    .trg_mode_in(modes),
    .hit_sig_stus_in(hit),
    .eff_trg_cnt_in(eff),
    .trg_busy_time_cnt_in(btime),
    .trg_busy_timer_rdy_in(rdy),
    .fifo_rd_in(rd),
    .fifo_data_out(dout),
    .fifo_empty_out(empty),
    .fifo_count_out(cnt),
    .frame_drop_cnt_out(drops),
    .busy_out(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 30)
        $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] d[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (d[j]) begin
      for (int b = 7; b >= 0; b--) begin
        if (c[15] ^ d[j][b]) c = (c << 1) ^ 16'h1021;
        else c = c << 1;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] pick_mode(input logic [47:0] m);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] mb = m[8*i +: 8];
      if (mb[7:6] == 2'b01) return {1'b1, 7'(i), mb};
    end
    return 16'h0000;
  endfunction

  function automatic void build_frame();
    logic [7:0]  body[$];
    logic [23:0] bt;
    logic [15:0] c;
    bt = rdy ? btime : 24'hFFFFFF;
    body = {m_seq[15:8], m_seq[7:0], m_sel, m_mode, hit[15:8], hit[7:0],
            eff[15:8], eff[7:0], bt[23:16], bt[15:8], bt[7:0]};
    c = crc16(body);
    mp.push_back(8'hEB);
    mp.push_back(8'h90);
    foreach (body[j]) mp.push_back(body[j]);
    mp.push_back(c[15:8]);
    mp.push_back(c[7:0]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq = {};
      mp = {};
      m_seq = '0;
      m_drop = '0;
      m_sel = '0;
      m_mode = '0;
    end else begin
      pre = mq.size();
      idle = (mp.size() == 0);
      if (rd && pre > 0) void'(mq.pop_front());
      if (!idle) mq.push_back(mp.pop_front());
      if (trg && enb) begin
        if (idle && 64 - pre >= 15) begin
          build_frame();
          m_seq++;
        end else begin
          if (m_drop != 16'hFFFF) m_drop++;
          if (idle) m_seq++;
        end
      end
      {m_sel, m_mode} = pick_mode(modes);
    end
  end

  always @(posedge clk) begin
    #1;
    if (run) begin
      chk("count", 32'(cnt), mq.size());
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("data", 32'(dout), (mq.size() != 0) ? 32'(mq[0]) : 0);
      chk("drops", 32'(drops), 32'(m_drop));
      chk("busy", 32'(busy), 32'(mp.size() != 0));
    end
  end

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk) trg = 1'b1;
    @(negedge clk) trg = 1'b0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got[i] = dout;
      rd = 1'b1;
    end
    @(negedge clk) rd = 1'b0;
  endtask

  initial begin
    logic [7:0]  ascii[$];
    logic [7:0]  zeros[$];
    logic [15:0] c;
    int          nb;

    ascii = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_ref_123456789", 32'(crc16(ascii)), 32'h29B1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    do_reset();
    chk("rst_count", 32'(cnt), 0);
    chk("rst_empty", 32'(empty), 1);

    // single all-zero frame
    pulse();
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 15);
    chk("frame_count", 32'(cnt), 15);
    read_n(15);
    chk("f1_sync_hi", 32'(got[0]), 32'hEB);
    chk("f1_sync_lo", 32'(got[1]), 32'h90);
    for (int i = 2; i < 13; i++) chk("f1_zero", 32'(got[i]), 0);
    zeros = {};
    for (int i = 0; i < 11; i++) zeros.push_back(8'h00);
    c = crc16(zeros);
    chk("f1_crc", {16'h0, got[13], got[14]}, 32'(c));

    // mode select, known pattern, then busy timer not ready
    modes = '0;
    modes[15:8] = 8'h45;
    modes[39:32] = 8'h41;
    hit = 16'h1234;
    eff = 16'hABCD;
    btime = 24'h5A6B7C;
    repeat (2) @(negedge clk);
    pulse();
    repeat (17) @(negedge clk);
    read_n(15);
    chk("f2_seq_lo", 32'(got[3]), 1);
    chk("f2_sel", 32'(got[4]), 32'h81);
    chk("f2_mode", 32'(got[5]), 32'h45);
    chk("f2_hit", {got[6], got[7]}, 32'h1234);
    chk("f2_busyt", {got[10], got[11], got[12]}, 32'h5A6B7C);
    rdy = 1'b0;
    pulse();
    repeat (17) @(negedge clk);
    read_n(15);
    chk("f3_busyt_ff", {got[10], got[11], got[12]}, 32'hFFFFFF);
    rdy = 1'b1;

    // FIFO fill to 60 bytes, fifth trigger dropped
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pulse();
      repeat (18) @(negedge clk);
    end
    chk("fill_count", 32'(cnt), 60);
    chk("fill_drops", 32'(drops), 1);
    read_n(15);
    pulse();
    repeat (18) @(negedge clk);
    read_n(60);
    chk("after_drop_seq_hi", 32'(got[47]), 0);
    chk("after_drop_seq_lo", 32'(got[48]), 5);

    // trigger held high for 40 cycles
    do_reset();
    @(negedge clk) trg = 1'b1;
    repeat (40) @(negedge clk);
    trg = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_drops", 32'(drops), 37);
    chk("held_count", 32'(cnt), 45);

    // reset mid-frame while reading continuously
    do_reset();
    rd = 1'b1;
    pulse();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_count", 32'(cnt), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_data", 32'(dout), 0);
    chk("midrst_busy", 32'(busy), 0);
    rd = 1'b0;
    pulse();
    repeat (17) @(negedge clk);
    read_n(15);
    chk("clean_sync", {got[0], got[1]}, 32'hEB90);
    chk("clean_seq", {got[2], got[3]}, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
